// File: rtl/div_pipe.sv
// ---------------------------------------------------------------------------
// div_pipe : fully pipelined restoring integer divider (signed or unsigned per
// operation). One operation can be accepted on every enabled cycle. The result
// appears N/R+2 enabled edges later, counting the edge that accepts it.
//
// Pipeline layout:
//   stage 0        : magnitudes, sign flags, divide-by-zero detect
//   stages 1..N/R  : R restoring quotient steps each, MSB first
//   output stage   : sign correction and divide-by-zero override
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset (wins over en and valid_i)
//   en             pipeline advance; 0 holds every register, outputs included
//   valid_i        operands present (sampled only when en=1)
//   signed_i       1 = two's-complement operands, 0 = unsigned
//   dividend_i     dividend, N bits
//   divisor_i      divisor, N bits
//   valid_o        result present
//   quotient_o     quotient, N bits
//   remainder_o    remainder, N bits
//   div_by_zero_o  divisor was zero for this result
// ---------------------------------------------------------------------------
module div_pipe #(
    parameter int N = 32,
    parameter int R = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_i,
    input  logic         signed_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         valid_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_by_zero_o
);
    localparam int S = N / R;  // number of iteration stages

    // Per-stage registers; index 0 is the conditioning stage, S the last
    // iteration stage.
    logic         v_q   [0:S];
    logic         qs_q  [0:S];
    logic         rs_q  [0:S];
    logic         dz_q  [0:S];
    logic [N-1:0] org_q [0:S];  // original dividend, for the div-by-zero result
    logic [N-1:0] rem_q [0:S];  // partial remainder (always < divisor magnitude)
    logic [N-1:0] quo_q [0:S];  // remaining dividend bits shifted out, quotient bits shifted in
    logic [N-1:0] den_q [0:S-1];  // divisor magnitude (not needed past the last step)

    // ------------------------------------------------------------------
    // Stage 0: input conditioning
    // ------------------------------------------------------------------
    logic         a_neg_d;
    logic         b_neg_d;
    logic [N-1:0] a_mag_d;
    logic [N-1:0] b_mag_d;

    always_comb begin
        a_neg_d = signed_i & dividend_i[N-1];
        b_neg_d = signed_i & divisor_i[N-1];
        // MIN negates to itself, which read as unsigned is the right magnitude.
        a_mag_d = a_neg_d ? (~dividend_i + 1'b1) : dividend_i;
        b_mag_d = b_neg_d ? (~divisor_i + 1'b1) : divisor_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q[0]   <= 1'b0;
            qs_q[0]  <= 1'b0;
            rs_q[0]  <= 1'b0;
            dz_q[0]  <= 1'b0;
            org_q[0] <= '0;
            rem_q[0] <= '0;
            quo_q[0] <= '0;
            den_q[0] <= '0;
        end else if (en) begin
            v_q[0]   <= valid_i;
            qs_q[0]  <= a_neg_d ^ b_neg_d;
            rs_q[0]  <= a_neg_d;
            dz_q[0]  <= (divisor_i == '0);
            org_q[0] <= dividend_i;
            rem_q[0] <= '0;
            quo_q[0] <= a_mag_d;
            den_q[0] <= b_mag_d;
        end
    end

    // ------------------------------------------------------------------
    // Stages 1..S: R restoring steps per stage
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 1; gi <= S; gi++) begin : g_stage
            logic [N-1:0] rem_d;
            logic [N-1:0] quo_d;

            always_comb begin : step
                logic [N:0]   shf;   // partial remainder after the shift, N+1 bits
                logic [N+1:0] diff;  // trial difference with a sign bit on top
                rem_d = rem_q[gi-1];
                quo_d = quo_q[gi-1];
                shf   = '0;
                diff  = '0;
                for (int j = 0; j < R; j++) begin
                    shf  = {rem_d, quo_d[N-1]};
                    diff = {1'b0, shf} - {2'b00, den_q[gi-1]};
                    // A non-negative difference is below the divisor, so it fits
                    // in N bits; on restore, shf itself is below the divisor.
                    if (!diff[N+1]) begin
                        rem_d = diff[N-1:0];
                        quo_d = {quo_d[N-2:0], 1'b1};
                    end else begin
                        rem_d = shf[N-1:0];
                        quo_d = {quo_d[N-2:0], 1'b0};
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q[gi]   <= 1'b0;
                    qs_q[gi]  <= 1'b0;
                    rs_q[gi]  <= 1'b0;
                    dz_q[gi]  <= 1'b0;
                    org_q[gi] <= '0;
                    rem_q[gi] <= '0;
                    quo_q[gi] <= '0;
                end else if (en) begin
                    v_q[gi]   <= v_q[gi-1];
                    qs_q[gi]  <= qs_q[gi-1];
                    rs_q[gi]  <= rs_q[gi-1];
                    dz_q[gi]  <= dz_q[gi-1];
                    org_q[gi] <= org_q[gi-1];
                    rem_q[gi] <= rem_d;
                    quo_q[gi] <= quo_d;
                end
            end

            if (gi < S) begin : g_den
                always_ff @(posedge clk) begin
                    if (rst) begin
                        den_q[gi] <= '0;
                    end else if (en) begin
                        den_q[gi] <= den_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: sign correction and divide-by-zero override
    // ------------------------------------------------------------------
    logic [N-1:0] quo_fix_d;
    logic [N-1:0] rem_fix_d;

    always_comb begin
        quo_fix_d = qs_q[S] ? (~quo_q[S] + 1'b1) : quo_q[S];
        rem_fix_d = rs_q[S] ? (~rem_q[S] + 1'b1) : rem_q[S];
        if (dz_q[S]) begin
            quo_fix_d = '1;
            rem_fix_d = org_q[S];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o       <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else if (en) begin
            valid_o       <= v_q[S];
            quotient_o    <= quo_fix_d;
            remainder_o   <= rem_fix_d;
            div_by_zero_o <= dz_q[S];
        end
    end
endmodule

// File: doc/div_pipe.md
Name: div_pipe

Overview:
- Parametrised, fully pipelined integer divider.
- Successor to the single-bit restoring slice.
  - Resolves R quotient bits per pipeline stage.
  - Supports signed and unsigned operation, selectable per operation.
  - Returns quotient and remainder with a valid flag and a divide-by-zero flag.
  - Whole pipeline stalls under a global enable.
- Sits in datapaths needing one division result per cycle at fixed latency, e.g. the CPU M-extension or DSP normalisation.

Parameters:
N  32  operand/result width in bits; even, >= 4
R  1  quotient bits resolved per stage; N % R == 0; 1 <= R <= 4
LAT  N/R+2  derived localparam, not user-set: input-to-output latency in enabled cycles

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  pipeline advance; 0 freezes every stage register, including outputs
valid_i  input  1  operands present this cycle (sampled when en=1)
signed_i  input  1  1 = two's-complement operands, 0 = unsigned
dividend_i  input  N  dividend
divisor_i  input  N  divisor
valid_o  output  1  result present on outputs
quotient_o  output  N  quotient
remainder_o  output  N  remainder
div_by_zero_o  output  1  divisor was zero for this result

Behaviour:
- Reset:
  - When rst=1 at a clock edge, all valid bits clear regardless of en.
  - All outputs clear: valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0.
  - All internal data registers clear.
  - Reset mid-operation drops every in-flight result; the first valid_o after reset belongs to an operation accepted after rst deasserts.
- Pipeline advance:
  - en=1: every stage moves one step.
  - en=0: every register holds, including outputs (valid_o stays at its last value).
  - Operands presented while en=0 are ignored.
- Latency:
  - An operation accepted at edge k (valid_i=1, en=1) appears on outputs after LAT enabled edges.
  - Throughput is one operation per enabled cycle; there is no internal backpressure.
  - valid=0 bubbles propagate with their slot; datapath contents of bubbles are don't-care except at reset.
- Stage 0 (input conditioning):
  - Latch the magnitudes |dividend| and |divisor|. Magnitude is computed on N bits; MIN maps to itself, interpreted as unsigned.
  - Latch the quotient sign qs = signed_i & (sign(dividend) ^ sign(divisor)).
  - Latch the remainder sign rs = signed_i & sign(dividend).
  - Latch dz = (divisor_i == 0).
  - Latch the original dividend, for the divide-by-zero result.
- Stages 1..N/R (iteration): each stage performs R restoring steps, MSB first.
  - Partial remainder is N+1 bits.
  - Each step: shift the next dividend bit into the partial remainder, then trial-subtract the divisor.
  - If the difference is non-negative: keep it and set the quotient bit to 1. Otherwise restore and set the bit to 0.
- Stage N/R+1 (output correction):
  - Negate the quotient if qs=1.
  - Negate the remainder if rs=1.
  - Divide-by-zero override (dz=1): quotient_o = all ones, remainder_o = original dividend, div_by_zero_o = 1. Applies in signed and unsigned mode.
  - Signed overflow (dividend = MIN, divisor = -1, signed): quotient_o = MIN, remainder_o = 0, div_by_zero_o = 0. This falls out of the magnitude arithmetic with no special case.
- Arithmetic rules:
  - Signed division truncates toward zero.
  - Remainder sign follows the dividend.
  - Remainder magnitude is always < |divisor| when divisor != 0.
  - For divisor != 0 the identity dividend = quotient*divisor + remainder (mod 2^N) holds.
- Simultaneous events: rst has priority over en and valid_i.
- Sidebands: signed_i, dz and the sign bits travel with their operation's slot; back-to-back operations of mixed mode must not interfere.

Test Plan:
1. Unsigned basic, N=32, R=1: dividend=100, divisor=7, signed=0 -> after exactly 34 enabled cycles, valid_o=1, quotient_o=14, remainder_o=2, div_by_zero_o=0.
2. Signed sign combinations, N=32, R=2, back-to-back:
   - -7/2 -> quotient -3, remainder -1.
   - 7/-2 -> quotient -3, remainder 1.
   - -7/-2 -> quotient 3, remainder -1.
   - Results appear on consecutive cycles, latency 18.
3. Boundary values, N=32, R=4:
   - 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0.
   - Same operands unsigned -> quotient 0, remainder 0x80000000.
   - 0xFFFFFFFF / 1 unsigned -> quotient 0xFFFFFFFF, remainder 0.
4. Divide by zero: 12345/0 unsigned and -5/0 signed -> quotient_o = 0xFFFFFFFF, remainder_o = 12345 and 0xFFFFFFFB respectively, div_by_zero_o=1.
5. Stall and reset:
   - Stall: issue 3 operations, hold en=0 for 5 cycles mid-flight -> outputs frozen, no result lost or duplicated, latency counts only enabled edges.
   - Reset: assert rst for 1 cycle with 3 operations in flight -> valid_o stays 0 until a new operation completes, and all outputs read 0 immediately after reset.
6. Random regression: 10k random operands and random signed_i with random en gaps, for R in {1,2,4} -> every result matches a reference model, and valid_o count equals the accepted count.
